// File: rtl/data_memory_bwe.sv
// Single-clock data memory with byte-lane writes, registered read port, address-error
// pulse and a zero sweep after reset. Optional macro MEM_FWD_EN: same-word write->read forwarding.
//
// state | meaning
// CLEAR | zeroing one word per cycle from clear_ptr; requests ignored (mem_busy=1)
// READY | normal operation until the next reset
module data_memory_bwe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_we,
    input  logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_re,
    input  logic [ADDR_WIDTH-1:0]   mem_raddr,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_rvalid,
    output logic                    mem_busy,
    output logic                    mem_err
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int PTR_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NBYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH    = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(MEM_SIZE - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [PTR_W-1:0]      clear_ptr, clear_ptr_nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic [ADDR_WIDTH-1:0] widx_full, ridx_full;
    logic [PTR_W-1:0]      widx, ridx;
    logic                  wr_ok, rd_ok;
    logic                  wr_req, rd_req, wr_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    // The alignment mask is empty for byte-wide memories, so OFF=0 needs no special case.
    assign widx_full = mem_addr >> OFF;
    assign ridx_full = mem_raddr >> OFF;
    assign wr_ok     = ((mem_addr & OFF_MASK) == '0) && (widx_full < DEPTH);
    assign rd_ok     = ((mem_raddr & OFF_MASK) == '0) && (ridx_full < DEPTH);
    assign widx      = widx_full[PTR_W-1:0];
    assign ridx      = ridx_full[PTR_W-1:0];

    assign mem_busy = (state == CLEAR);
    assign wr_req   = !mem_busy && mem_we;
    assign rd_req   = !mem_busy && mem_re;
    assign wr_fire  = wr_req && wr_ok;

    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        if (state == CLEAR) begin
            clear_ptr_nxt = clear_ptr + PTR_W'(1);
            if (clear_ptr == LAST_PTR) begin
                state_nxt     = READY;
                clear_ptr_nxt = '0;
            end
        end
    end

    always_comb begin
        rd_word = mem[ridx];
`ifdef MEM_FWD_EN
        if (wr_fire && (widx == ridx)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (mem_be[i]) begin
                    rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clear_ptr  <= '0;
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            clear_ptr  <= clear_ptr_nxt;
            mem_rvalid <= rd_req;
            mem_err    <= (rd_req && !rd_ok) || (wr_req && !wr_ok);
            if (rd_req) begin
                mem_rdata <= rd_ok ? rd_word : '0;
            end
        end
    end

    // Storage has no reset of its own; the CLEAR sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clear_ptr] <= '0;
            end else if (wr_fire) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (mem_be[i]) begin
                        mem[widx][8*i +: 8] <= mem_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bwe.sv
// Self-checking bench for data_memory_bwe: directed scenarios followed by random traffic,
// all checked against a word-array reference model. Honours MEM_FWD_EN.
module tb_data_memory_bwe;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_busy;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_rdata;
    int          sweep_left;

    data_memory_bwe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .mem_busy  (mem_busy),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    // One clock: drive inputs, predict the outcome of the edge, then compare after it.
    task automatic cyc(input logic r, input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input logic re, input logic [31:0] ra);
        logic        exp_rv, exp_err;
        logic [31:0] cur;
        int          wi, ri;
        bit          wok, rok;
        rst = r; mem_we = we; mem_be = be; mem_addr = a; mem_wdata = wd;
        mem_re = re; mem_raddr = ra;
        wok = addr_ok(a);
        rok = addr_ok(ra);
        wi  = wok ? int'(a / 4) : 0;
        ri  = rok ? int'(ra / 4) : 0;
        exp_rv  = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            sweep_left = DEPTH;
            exp_rdata  = '0;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            if (re) begin
                exp_rv = 1'b1;
                if (rok) begin
                    cur = model[ri];
`ifdef MEM_FWD_EN
                    if (we && wok && wi == ri) cur = merge(cur, wd, be);
`endif
                    exp_rdata = cur;
                end else begin
                    exp_rdata = '0;
                    exp_err   = 1'b1;
                end
            end
            if (we) begin
                if (wok) model[wi] = merge(model[wi], wd, be);
                else exp_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("busy",   {31'd0, mem_busy},   {31'd0, sweep_left > 0});
        check("rvalid", {31'd0, mem_rvalid}, {31'd0, exp_rv});
        check("err",    {31'd0, mem_err},    {31'd0, exp_err});
        check("rdata",  mem_rdata,           exp_rdata);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        cyc(1'b0, 1'b1, be, a, d, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a);
    endtask

    initial begin
        logic [31:0] ra, wa;
        logic [3:0]  be;
        logic        we, re;
        int          sel;
        sweep_left = DEPTH;
        exp_rdata  = '0;

        // 1. reset sweep, then a read of cleared memory
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) idle();
        check("sweep_done_busy", {31'd0, mem_busy}, 32'd0);
        rd(32'h100);
        check("t1_rdata", mem_rdata, 32'h0000_0000);

        // 2. full write, then read
        wr(32'h100, 4'hF, 32'hABCD_1234);
        rd(32'h100);
        check("t2_rdata", mem_rdata, 32'hABCD_1234);

        // 3. partial write
        wr(32'h100, 4'h2, 32'h0000_EE00);
        rd(32'h100);
        check("t3_rdata", mem_rdata, 32'hABCD_EE34);

        // 4. same-cycle collision
        cyc(1'b0, 1'b1, 4'hF, 32'h100, 32'h1111_1111, 1'b1, 32'h100);
`ifdef MEM_FWD_EN
        check("t4_collide", mem_rdata, 32'h1111_1111);
`else
        check("t4_collide", mem_rdata, 32'hABCD_EE34);
`endif
        rd(32'h100);
        check("t4_after", mem_rdata, 32'h1111_1111);

        // 5. address errors
        rd(32'h102);
        check("t5_mis_err", {31'd0, mem_err}, 32'd1);
        wr(32'h1000, 4'hF, 32'hDEAD_BEEF);
        check("t5_oor_err", {31'd0, mem_err}, 32'd1);
        rd(32'hFFC);
        check("t5_last_word", mem_rdata, 32'h0);

        // 6. reset mid-clear while busy-time requests are presented
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 500; i++)
            cyc(1'b0, 1'b1, 4'hF, 32'h200, 32'h5A5A_5A5A, 1'b1, 32'h200);
        cyc(1'b1, 1'b1, 4'hF, 32'h200, 32'h5A5A_5A5A, 1'b1, 32'h200);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 1'b1, 4'hF, 32'h200, 32'h5A5A_5A5A, 1'b1, 32'h200);
        check("t6_busy_end", {31'd0, mem_busy}, 32'd0);
        rd(32'h200);
        check("t6_rdata", mem_rdata, 32'h0);
        rd(32'h100);
        check("t6_swept", mem_rdata, 32'h0);

        // 7. random traffic over a small window plus occasional bad addresses
        for (int n = 0; n < 600; n++) begin
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            wa  = 32'($urandom_range(0, 15)) * 4;
            if (sel == 0) wa = wa + 32'($urandom_range(1, 3));
            else if (sel == 1) wa = 32'h1000 + wa;
            be  = addr_ok(wa) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
            sel = int'($urandom_range(0, 9));
            ra  = 32'($urandom_range(0, 15)) * 4;
            if (sel == 0) ra = ra + 32'($urandom_range(1, 3));
            else if (sel == 1) ra = 32'hFFFF_FFF0;
            cyc(1'b0, we, be, wa, $urandom, re, ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_bwe.md
Name: data_memory_bwe

Overview:
Parametrised single-clock data memory, next generation of the team's DataMemory.
- Adds byte-write strobes, a registered read port with a valid flag, and address error detection.
- Adds a self-clearing sequence after reset.
- Sits between the core's load/store unit and on-chip RAM; one write and one read request per cycle.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8, at least 8.
- ADDR_WIDTH, 32, byte-address width.
- MEM_SIZE, 1024, depth in words; at least 2.
- Derived: NBYTES = DATA_WIDTH/8; OFF = log2(NBYTES); PTR_W = clog2(MEM_SIZE).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- mem_we  in  1  write request.
- mem_be  in  NBYTES  byte-lane write enables; bit i covers wdata[8i+7:8i].
- mem_addr  in  ADDR_WIDTH  write byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_re  in  1  read request.
- mem_raddr  in  ADDR_WIDTH  read byte address.
- mem_rdata  out  DATA_WIDTH  registered read data.
- mem_rvalid  out  1  mem_rdata valid; one-cycle pulse per accepted read.
- mem_busy  out  1  clear sequence in progress; requests are ignored.
- mem_err  out  1  registered address-error pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to CLEAR and clear_ptr to 0.
  - mem_rdata=0, mem_rvalid=0, mem_err=0, mem_busy=1.
  - Reset asserted mid-CLEAR restarts the sweep at word 0.
- FSM state CLEAR:
  - Each cycle writes 0 to word clear_ptr, then clear_ptr increments.
  - After writing word MEM_SIZE-1 the FSM enters READY; mem_busy=0 from the following cycle.
  - CLEAR therefore lasts exactly MEM_SIZE cycles after reset deasserts.
- FSM state READY: terminal until the next reset.
- While mem_busy=1:
  - mem_we and mem_re are ignored: no write, no mem_rvalid, no mem_err.
- Address decode, applied to each port separately:
  - Word index = addr >> OFF.
  - The address is invalid if addr[OFF-1:0] != 0 (misaligned) or word index >= MEM_SIZE.
- Write (READY, mem_we=1, valid address):
  - At the edge, only the byte lanes with mem_be[i]=1 are updated.
  - mem_be=0 performs no write and raises no error.
- Read (READY, mem_re=1):
  - Latency 1: at the next edge mem_rvalid=1 and mem_rdata = word contents.
  - With mem_re=0, mem_rvalid=0 and mem_rdata holds its last value.
  - Back-to-back reads are supported, one per cycle.
- Errors:
  - mem_err=1 for one cycle after any accepted request with an invalid address; the write and read errors are ORed.
  - Invalid read: mem_rvalid=1 and mem_rdata=0.
  - Invalid write: memory is unchanged.
- Same-cycle write and read to the same valid word: behaviour depends on MEM_FWD_EN (see Optional Feature).
- Write and read to different words in the same cycle are fully independent.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: a same-cycle, same-word read returns the post-write word.
  - Lanes with mem_be=1 take mem_wdata; the other lanes take the stored value.
- Undefined: read-first; a same-cycle, same-word read returns the pre-write contents.

Test Plan:
All scenarios use DATA_WIDTH=32, MEM_SIZE=1024.
1. Reset sweep: rst=1 for 2 cycles, then release.
   -> mem_busy=1 for exactly 1024 cycles, then 0.
   -> Then read 0x100 -> next cycle mem_rvalid=1, mem_rdata=0x00000000.
2. Full write then read: write 0x100, be=0xF, data 0xABCD1234; next cycle read 0x100.
   -> One cycle later mem_rvalid=1, mem_rdata=0xABCD1234, mem_err=0.
3. Partial write: write 0x100, be=0x2, data 0x0000EE00; then read 0x100.
   -> mem_rdata=0xABCDEE34.
4. Same-cycle collision: write 0x100, be=0xF, data 0x11111111, with a read of 0x100 in the same cycle.
   -> rdata=0xABCDEE34 without MEM_FWD_EN; 0x11111111 with it.
   -> A subsequent read returns 0x11111111 in both builds.
5. Errors:
   - Read 0x102 -> mem_err=1, mem_rvalid=1, mem_rdata=0.
   - Write 0x1000, data 0xDEADBEEF -> mem_err=1.
   - Read 0xFFC -> value unchanged from prior contents (0 after sweep), mem_err=0.
6. Reset mid-clear and busy writes: during CLEAR, request write 0x200, data 0x5A5A5A5A; assert rst at sweep cycle 500.
   -> mem_busy stays 1 for 1024 more cycles after release.
   -> Read 0x200 returns 0, with no rvalid or err during busy.
